// File: rtl/simd_accumulator_c3x2_12bits.sv
// Block accumulator for the configurable 6x6 / dual 3x3 multiplier: sums ACC_LEN
// product beats (or fewer on flush) as one 24-bit lane or two independent 12-bit lanes.
module simd_accumulator_c3x2_12bits #(
  parameter int ACC_LEN = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] C,
  input  logic        A_sign,
  input  logic        B_sign,
  input  logic        HALF_0,
  input  logic        HALF_1,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [23:0] ACC,
  output logic [7:0]  beat_cnt,
  output logic [1:0]  ovf,
  output logic        mode_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] LEN = 8'(ACC_LEN);

  state_t      state;
  logic        half_q;
  logic        sgn_q;

  logic        idle;
  logic        blk_half;
  logic        blk_sgn;
  logic [23:0] base;
  logic [1:0]  ovf_base;
  logic        merr_base;
  logic [7:0]  cnt_next;
  logic [23:0] ext_f;
  logic [24:0] sum_f;
  logic        ov_f;
  logic [11:0] ext_h1;
  logic [11:0] ext_h0;
  logic [12:0] sum_h1;
  logic [12:0] sum_h0;
  logic        ov_h1;
  logic        ov_h0;
  logic [23:0] next_acc;
  logic [1:0]  add_ovf;
  logic        merr_beat;

  // Handshake: a beat transfers on a rising edge where in_valid & in_ready, a result
  // transfers where out_valid & out_ready; in_ready and out_valid are mutually exclusive.
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign state_dbg = state;

  always_comb begin
    idle      = (state == IDLE);
    // The first beat of a block sees a zero base and its own mode/sign, not the latched ones.
    blk_half  = idle ? (HALF_1 & ~HALF_0) : half_q;
    blk_sgn   = idle ? (A_sign & B_sign) : sgn_q;
    base      = idle ? 24'h000000 : ACC;
    ovf_base  = idle ? 2'b00 : ovf;
    merr_base = idle ? 1'b0 : mode_err;
    cnt_next  = (idle ? 8'd0 : beat_cnt) + 8'd1;
    merr_beat = (HALF_0 == HALF_1);

    ext_f  = blk_sgn ? {{12{C[11]}}, C} : {12'h000, C};
    sum_f  = {1'b0, base} + {1'b0, ext_f};
    ov_f   = blk_sgn ? ((base[23] == ext_f[23]) && (sum_f[23] != base[23])) : sum_f[24];

    ext_h1 = blk_sgn ? {{6{C[11]}}, C[11:6]} : {6'h00, C[11:6]};
    ext_h0 = blk_sgn ? {{6{C[5]}}, C[5:0]} : {6'h00, C[5:0]};
    sum_h1 = {1'b0, base[23:12]} + {1'b0, ext_h1};
    sum_h0 = {1'b0, base[11:0]} + {1'b0, ext_h0};
    ov_h1  = blk_sgn ? ((base[23] == ext_h1[11]) && (sum_h1[11] != base[23])) : sum_h1[12];
    ov_h0  = blk_sgn ? ((base[11] == ext_h0[11]) && (sum_h0[11] != base[11])) : sum_h0[12];

    next_acc = blk_half ? {sum_h1[11:0], sum_h0[11:0]} : sum_f[23:0];
    add_ovf  = blk_half ? {ov_h1, ov_h0} : {1'b0, ov_f};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      half_q   <= 1'b0;
      sgn_q    <= 1'b0;
      ACC      <= 24'h000000;
      beat_cnt <= 8'd0;
      ovf      <= 2'b00;
      mode_err <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (in_valid) begin
            if (idle) begin
              half_q <= blk_half;
              sgn_q  <= blk_sgn;
            end
            ACC      <= next_acc;
            ovf      <= ovf_base | add_ovf;
            mode_err <= merr_base | merr_beat;
            beat_cnt <= cnt_next;
            // Flush only closes a block already in progress; in IDLE it is ignored.
            if ((cnt_next == LEN) || ((state == ACCUM) && flush)) state <= HOLD;
            else state <= ACCUM;
          end else if ((state == ACCUM) && flush) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_accumulator_c3x2_12bits.sv
// Bench for simd_accumulator_c3x2_12bits: two instances (ACC_LEN 4 and 128) share one
// stimulus stream and are compared every cycle against an arithmetic block model.
module tb_simd_accumulator_c3x2_12bits;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] c = 12'h000;
  logic        a_sign = 1'b0, b_sign = 1'b0, half_0 = 1'b1, half_1 = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;

  logic [1:0]        in_ready_v, out_valid_v, merr_v;
  logic [1:0][23:0]  acc_v;
  logic [1:0][7:0]   cnt_v;
  logic [1:0][1:0]   ovf_v, st_v;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  simd_accumulator_c3x2_12bits #(.ACC_LEN(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .C(c), .A_sign(a_sign), .B_sign(b_sign),
    .HALF_0(half_0), .HALF_1(half_1), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .flush(flush), .ACC(acc_v[0]), .beat_cnt(cnt_v[0]), .ovf(ovf_v[0]),
    .mode_err(merr_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .state_dbg(st_v[0]));

  simd_accumulator_c3x2_12bits #(.ACC_LEN(128)) dut128 (
    .clk(clk), .reset_n(reset_n), .C(c), .A_sign(a_sign), .B_sign(b_sign),
    .HALF_0(half_0), .HALF_1(half_1), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .flush(flush), .ACC(acc_v[1]), .beat_cnt(cnt_v[1]), .ovf(ovf_v[1]),
    .mode_err(merr_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .state_dbg(st_v[1]));

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 no block open, 1 block open, 2 result offered
  int        len[2] = '{4, 128};
  int        m_phase[2];
  bit        m_half[2], m_sgn[2];
  longint    m_full[2], m_l1[2], m_l0[2];
  int        m_cnt[2];
  bit [1:0]  m_ovf[2];
  bit        m_merr[2];

  // Add an aw-bit addend to a w-bit lane as true integers; overflow means the exact
  // sum falls outside the lane's representable range.
  task automatic lane_add(input int w, input int aw, input longint acc_raw,
                          input longint c_raw, input bit sgn,
                          output longint new_raw, output bit ov);
    longint m, am, a, x, t;
    m  = longint'(1) << w;
    am = longint'(1) << aw;
    a  = acc_raw;
    x  = c_raw;
    if (sgn) begin
      if (a >= m / 2) a -= m;
      if (x >= am / 2) x -= am;
    end
    t = a + x;
    ov = sgn ? ((t < -(m / 2)) || (t >= m / 2)) : (t >= m);
    new_raw = ((t % m) + m) % m;
  endtask

  task automatic model_step(input int i);
    int was;
    bit ov;
    was = m_phase[i];
    if (was == 2) begin
      if (out_ready) m_phase[i] = 0;
    end else if (in_valid) begin
      if (was == 0) begin
        m_half[i] = half_1 && !half_0;
        m_sgn[i]  = a_sign && b_sign;
        m_full[i] = 0; m_l1[i] = 0; m_l0[i] = 0;
        m_ovf[i]  = 2'b00; m_merr[i] = 1'b0; m_cnt[i] = 0;
      end
      if (half_0 == half_1) m_merr[i] = 1'b1;
      if (m_half[i]) begin
        lane_add(12, 6, m_l1[i], longint'(c[11:6]), m_sgn[i], m_l1[i], ov);
        if (ov) m_ovf[i][1] = 1'b1;
        lane_add(12, 6, m_l0[i], longint'(c[5:0]), m_sgn[i], m_l0[i], ov);
        if (ov) m_ovf[i][0] = 1'b1;
      end else begin
        lane_add(24, 12, m_full[i], longint'(c), m_sgn[i], m_full[i], ov);
        if (ov) m_ovf[i][0] = 1'b1;
      end
      m_cnt[i]++;
      m_phase[i] = ((m_cnt[i] == len[i]) || (flush && was == 1)) ? 2 : 1;
    end else if (was == 1 && flush) begin
      m_phase[i] = 2;
    end
  endtask

  function automatic longint model_acc(input int i);
    return m_half[i] ? ((m_l1[i] << 12) | m_l0[i]) : m_full[i];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_phase[i] = 0; m_cnt[i] = 0; m_ovf[i] = 2'b00; m_merr[i] = 1'b0;
        m_full[i] = 0; m_l1[i] = 0; m_l0[i] = 0; m_half[i] = 1'b0; m_sgn[i] = 1'b0;
      end else begin
        model_step(i);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("in_ready[%0d]", i), longint'(in_ready_v[i]), longint'(m_phase[i] != 2));
        chk($sformatf("out_valid[%0d]", i), longint'(out_valid_v[i]), longint'(m_phase[i] == 2));
        if (m_phase[i] == 2) begin
          chk($sformatf("acc[%0d]", i), longint'(acc_v[i]), model_acc(i));
          chk($sformatf("beat_cnt[%0d]", i), longint'(cnt_v[i]), longint'(m_cnt[i]));
          chk($sformatf("ovf[%0d]", i), longint'(ovf_v[i]), longint'(m_ovf[i]));
          chk($sformatf("mode_err[%0d]", i), longint'(merr_v[i]), longint'(m_merr[i]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic beats(input int n, input logic [11:0] cv, input bit as, input bit bs,
                       input bit h0, input bit h1);
    for (int k = 0; k < n; k++) begin
      c = cv; a_sign = as; b_sign = bs; half_0 = h0; half_1 = h1; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic sync_idle();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_result(input string tag, input int i, input longint acc_e,
                            input longint cnt_e, input longint ovf_e, input longint merr_e);
    chk({tag, "_out_valid"}, longint'(out_valid_v[i]), 1);
    chk({tag, "_acc"}, longint'(acc_v[i]), acc_e);
    chk({tag, "_cnt"}, longint'(cnt_v[i]), cnt_e);
    chk({tag, "_ovf"}, longint'(ovf_v[i]), ovf_e);
    chk({tag, "_merr"}, longint'(merr_v[i]), merr_e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #3;
    for (int i = 0; i < 2; i++) begin
      chk("rst_acc", longint'(acc_v[i]), 0);
      chk("rst_cnt", longint'(cnt_v[i]), 0);
      chk("rst_ovf", longint'(ovf_v[i]), 0);
      chk("rst_out_valid", longint'(out_valid_v[i]), 0);
      chk("rst_in_ready", longint'(in_ready_v[i]), 1);
    end
    @(negedge clk); @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // full unsigned 63x63
    sync_idle();
    beats(4, 12'd3969, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_result("full_u", 0, 24'd15876, 4, 0, 0);
    chk("full_u_in_ready", longint'(in_ready_v[0]), 0);
    @(negedge clk);
    chk("full_u_one_cycle", longint'(out_valid_v[0]), 0);

    // full signed -32x31
    sync_idle();
    beats(4, 12'hC20, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_result("full_s", 0, 24'hFFF080, 4, 0, 0);

    // half unsigned 7x7 per lane
    sync_idle();
    beats(4, 12'hC71, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_result("half_u", 0, 24'h0C40C4, 4, 0, 0);

    // mode error on a later beat; latched full mode keeps applying
    sync_idle();
    beats(1, 12'h001, 1'b0, 1'b0, 1'b1, 1'b0);
    beats(1, 12'h002, 1'b0, 1'b0, 1'b1, 1'b1);
    beats(1, 12'h004, 1'b1, 1'b1, 1'b0, 1'b1);
    beats(1, 12'h008, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_result("mode_err", 0, 24'h00000F, 4, 0, 1);

    // long half unsigned block with flush, both lanes wrap
    sync_idle();
    beats(84, 12'hC71, 1'b0, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk_result("half_flush", 1, 24'h014014, 84, 2'b11, 0);

    // half signed, both lanes overflow below -2048
    sync_idle();
    beats(66, 12'h820, 1'b1, 1'b1, 1'b0, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk_result("half_s_ovf", 1, 24'h7C07C0, 66, 2'b11, 0);

    // backpressure after a 2-beat flush
    sync_idle();
    out_ready = 1'b0;
    beats(2, 12'h123, 1'b0, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_result("bp", 1, 24'h000246, 2, 0, 0);
      chk("bp_in_ready", longint'(in_ready_v[1]), 0);
      in_valid = 1'b1;
      c = 12'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", longint'(out_valid_v[1]), 0);
    chk("bp_release_in_ready", longint'(in_ready_v[1]), 1);

    // reset mid-block, then a fresh full-mode block
    sync_idle();
    beats(3, 12'hC71, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_acc", longint'(acc_v[1]), 0);
    chk("mid_rst_cnt", longint'(cnt_v[1]), 0);
    chk("mid_rst_ovf", longint'(ovf_v[1]), 0);
    chk("mid_rst_merr", longint'(merr_v[1]), 0);
    chk("mid_rst_out_valid", longint'(out_valid_v[1]), 0);
    chk("mid_rst_in_ready", longint'(in_ready_v[1]), 1);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    beats(4, 12'h041, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_result("post_rst", 0, 24'h000104, 4, 0, 0);

    // randomized traffic, short blocks then long blocks
    sync_idle();
    for (int k = 0; k < 3000; k++) begin
      int r;
      in_valid = ($urandom_range(0, 99) < 70);
      c = 12'($urandom);
      a_sign = 1'($urandom);
      b_sign = 1'($urandom);
      r = $urandom_range(0, 9);
      if (r < 4) begin half_0 = 1'b1; half_1 = 1'b0; end
      else if (r < 8) begin half_0 = 1'b0; half_1 = 1'b1; end
      else if (r == 8) begin half_0 = 1'b0; half_1 = 1'b0; end
      else begin half_0 = 1'b1; half_1 = 1'b1; end
      flush = ($urandom_range(0, 99) < ((k < 1500) ? 10 : 1));
      out_ready = ($urandom_range(0, 99) < 60);
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/simd_accumulator_c3x2_12bits.md
SIMD_ACCUMULATOR_C3X2_12BITS -- requirements
Module: simd_accumulator_c3x2_12bits

Interface
REQ-001 Parameter ACC_LEN, default 4, number of accepted beats per accumulation block (range 1..255).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 C  input  12  product word from the upstream configurable 6x6 / dual 3x3 multiplier.
REQ-005 A_sign, B_sign  input  1 each  operand signedness; the product is signed when both are 1.
REQ-006 HALF_0, HALF_1  input  1 each  multiplier mode: 10 = one 6x6 product, 01 = two 3x3 products (C[11:6], C[5:0]).
REQ-007 in_valid / in_ready  input / output  1 each  beat handshake; a beat is accepted when both are 1 on a clock edge.
REQ-008 flush  input  1  closes the current partial block early.
REQ-009 ACC  output  24  block result: full mode one 24-bit sum; half mode lane1 = ACC[23:12], lane0 = ACC[11:0].
REQ-010 beat_cnt  output  8  number of beats contained in ACC.
REQ-011 ovf  output  2  sticky per-lane overflow for the block (full mode: ovf[0] only, ovf[1]=0).
REQ-012 mode_err  output  1  sticky: a beat in the block carried HALF_0 == HALF_1.
REQ-013 out_valid / out_ready  output / input  1 each  result handshake.

Function
REQ-014 States: IDLE, ACCUM, HOLD; in_ready = 1 in IDLE and ACCUM, 0 in HOLD; out_valid = 1 only in HOLD.
REQ-015 IDLE + accepted beat: latch mode (half = HALF_1 & ~HALF_0) and sign (A_sign & B_sign) for the block; clear accumulator, ovf and mode_err; add the beat; count = 1; go to ACCUM (or HOLD when ACC_LEN = 1).
REQ-016 Mode and sign inputs on later beats of a block are ignored; HALF_0 == HALF_1 on any accepted beat sets mode_err and the beat is processed in the latched mode.
REQ-017 Full mode: acc += C extended to 24 bits (sign-extended if signed, else zero-extended), 24-bit wrap.
REQ-018 Half mode: lane1 += ext(C[11:6]) and lane0 += ext(C[5:0]), each extended to 12 bits, each wraps at 12 bits independently; no carry crosses bit 11/12.
REQ-019 Overflow per lane: unsigned = carry-out of lane MSB; signed = both addends same sign and result sign differs; sets the lane's ovf bit, never clears within the block.
REQ-020 ACCUM: each accepted beat increments count; when count reaches ACC_LEN, result is registered and state goes to HOLD on the same edge.
REQ-021 flush in ACCUM with no accepted beat: go to HOLD with current partial result and count; flush and accepted beat on the same edge: beat included, then HOLD; flush in IDLE or HOLD is ignored.
REQ-022 HOLD: ACC, beat_cnt, ovf, mode_err remain stable; on out_valid & out_ready go to IDLE (no beat accepted on that edge).
REQ-023 Latency: result visible on outputs one clock after the edge accepting the final beat (or the flush edge).
REQ-024 beat_cnt saturates never; ACC_LEN bounds it.

Reset
REQ-025 reset_n low asynchronously forces state IDLE, ACC = 0, beat_cnt = 0, ovf = 0, mode_err = 0, out_valid = 0, in_ready = 1, discarding any partial block.
REQ-026 Release of reset_n is sampled on the next clk rising edge; no beat is accepted while reset_n is low.

Verification
REQ-027 Full unsigned, ACC_LEN=4, four beats C=12'd3969 (63x63), out_ready=1 -> ACC=24'd15876, beat_cnt=4, ovf=00, out_valid one cycle.
REQ-028 Full signed, four beats C=12'hC20 (-32x31) -> ACC=24'hFFF080, ovf=00.
REQ-029 Half unsigned, four beats C=12'hC71 (7x7 per lane) -> ACC=24'h0C40C4, no cross-lane carry, ovf=00.
REQ-030 Half unsigned, ACC_LEN=128, 84 beats C=12'hC71 then flush -> ACC=24'h014014, beat_cnt=84, ovf=11.
REQ-031 Backpressure: flush after 2 beats with out_ready=0 for 5 cycles -> out_valid held, in_ready=0, outputs stable, beat_cnt=2; IDLE after out_ready.
REQ-032 reset_n pulsed low mid-block after 3 beats -> all outputs cleared immediately; next block starts from zero with newly latched mode.
